// File: rtl/timer_bcd_countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_bcd_countdown_pkg
// Description : Shared state encoding, BCD limit and clamp helper for the
//               two-digit BCD countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_bcd_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Preset digits above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_bcd_countdown_bcd_digit_down.sv
`default_nettype none
// ============================================================================
// Module      : timer_bcd_countdown_bcd_digit_down
// Description : One BCD digit with clamped load, decrement enable and a
//               borrow-out that fires when a decrement wraps 0 -> 9.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bcd_countdown_bcd_digit_down
    import timer_bcd_countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec_en,
    output logic [3:0] o_digit,
    output logic       o_borrow
);

    logic [3:0] r_digit;

    // Digit register: load has priority over decrement; 0 wraps to 9.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= bcd_clamp(i_load_val);
        end else if (i_dec_en) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : (r_digit - 4'd1);
        end
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_dec_en && (r_digit == 4'd0);

endmodule
`default_nettype wire

// File: rtl/timer_bcd_countdown.sv
`default_nettype none
// ============================================================================
// Module      : timer_bcd_countdown
// Description : Two-digit BCD countdown timer (00-99) with load, start,
//               pause/resume, one-cycle done pulse and a free-running
//               display scan select.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bcd_countdown
    import timer_bcd_countdown_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 50000000,
    parameter int unsigned SCAN_DIV = 50000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_units,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       scan_sel,
    output logic       running,
    output logic       done
);

    localparam int unsigned PRESC_W = $clog2(CLK_DIV);
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(CLK_DIV - 1);
    localparam logic [SCAN_W-1:0]  c_scan_max  = SCAN_W'(SCAN_DIV - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  w_presc_next;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic                r_scan_sel;
    logic                r_running;
    logic                r_done;
    logic                w_done_next;
    logic                w_tick;
    logic                w_units_borrow;
    logic                w_unused_tens_borrow;
    logic                w_tick_hits_zero;

    // A tick from 01 is the only way the count can land on 00.
    assign w_tick_hits_zero = (tens == 4'd0) && (units == 4'd1);

    // Units decrement on each tick; tens decrement on units borrow.
    timer_bcd_countdown_bcd_digit_down u_units (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (load),
        .i_load_val (preset_units),
        .i_dec_en   (w_tick),
        .o_digit    (units),
        .o_borrow   (w_units_borrow)
    );

    timer_bcd_countdown_bcd_digit_down u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (load),
        .i_load_val (preset_tens),
        .i_dec_en   (w_units_borrow),
        .o_digit    (tens),
        .o_borrow   (w_unused_tens_borrow)
    );

    // Next-state, prescaler and tick decisions; load overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_done_next  = 1'b0;
        w_tick       = 1'b0;
        if (load) begin
            w_state_next = IDLE;
            w_presc_next = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (r_presc == c_presc_max) begin
                        w_tick       = 1'b1;
                        w_presc_next = '0;
                        if (w_tick_hits_zero) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else if (pause) begin
                            w_state_next = PAUSED;
                        end
                    end else if (pause) begin
                        w_state_next = PAUSED;
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        w_state_next = RUN;
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        if ((tens == 4'd0) && (units == 4'd0)) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = RUN;
                            w_presc_next = '0;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // State, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_running <= (w_state_next == RUN);
            r_done    <= w_done_next;
        end
    end

    // Free-running scan divider: toggle scan_sel every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_sel <= 1'b0;
        end else if (r_scan_cnt == c_scan_max) begin
            r_scan_cnt <= '0;
            r_scan_sel <= ~r_scan_sel;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign scan_sel = r_scan_sel;
    assign running  = r_running;
    assign done     = r_done;

endmodule
`default_nettype wire
